// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//
// Shared types and helpers for the data-memory access controller.
//   dmem_size_e   : access size encoding as it arrives on req_size
//   dmem_state_e  : controller sequencing states
//   is_misaligned : alignment rule for halfword/word accesses
//   is_bad_request: illegal size or misaligned, i.e. answered without memory
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } dmem_size_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR     = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RMW_WR = 3'd4,
      ST_RESP   = 3'd5
   } dmem_state_e;

   // Bytes can land anywhere; halfwords need an even address, words a
   // multiple of four. The illegal size is rejected separately.
   function automatic logic is_misaligned(input dmem_size_e size,
                                          input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = offset[0];
         SZ_WORD: mis = (offset != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic is_bad_request(input dmem_size_e size,
                                           input logic [1:0] offset);
      return (size == SZ_ILLEGAL) || is_misaligned(size, offset);
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// -----------------------------------------------------------------------------
// dmem_lane_unit
//
// Purely combinational little-endian lane logic for the access controller.
//   mem_word    in  32  word currently returned by the memory
//   store_data  in  32  right-justified store data
//   size        in  2   access size (dmem_size_e)
//   offset      in  2   byte offset within the word
//   zero_ext    in  1   zero-extend sub-word loads instead of sign-extending
//   merged_word out 32  mem_word with the addressed lane(s) replaced
//   load_data   out 32  addressed lane(s) of mem_word, extended to 32 bits
// -----------------------------------------------------------------------------
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   input  dmem_size_e  size,
   input  logic [1:0]  offset,
   input  logic        zero_ext,
   output logic [31:0] merged_word,
   output logic [31:0] load_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Store merge: byte lane = offset, halfword lanes chosen by offset[1].
   always_comb begin
      merged_word = mem_word;
      case (size)
         SZ_BYTE: merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
         SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
         SZ_WORD: merged_word = store_data;
         default: merged_word = mem_word;
      endcase
   end

   // Load extract and extend; the extension bit is masked off for lbu/lhu.
   always_comb begin
      byte_lane = mem_word[{offset, 3'b000} +: 8];
      half_lane = mem_word[{offset[1], 4'b0000} +: 16];
      load_data = mem_word;
      case (size)
         SZ_BYTE: load_data = {{24{byte_lane[7] & ~zero_ext}}, byte_lane};
         SZ_HALF: load_data = {{16{half_lane[15] & ~zero_ext}}, half_lane};
         default: load_data = mem_word;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequences MEM-stage loads and stores onto a single-port, word-wide data
// memory. Sub-word stores are read-modify-write; loads are sign- or
// zero-extended. Misaligned and illegal requests are answered with an error
// and never touch the memory.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   req_valid/req_ready                   request handshake
//   req_write, req_size, req_unsigned     request type
//   req_addr, req_wdata                   byte address, right-justified data
//   rsp_valid/rsp_ready                   response handshake
//   rsp_rdata, rsp_err                    extended load data, error flag
//   mem_we, mem_addr, mem_wdata           memory command (word aligned)
//   mem_rdata, mem_err                    memory read data (one cycle late)
//   busy                                  controller not idle
// -----------------------------------------------------------------------------
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err,
   output logic              busy
);

   // The lane logic is written for a 32-bit word only.
   if (DATA_W != 32) begin : g_data_w_check
      $error("dmem_access_ctrl: DATA_W must be 32");
   end

   dmem_state_e       state_q;
   dmem_state_e       state_d;

   dmem_size_e        size_q;
   logic              zero_ext_q;
   logic [1:0]        offset_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              load_pending_q;

   dmem_size_e        req_size_e;
   logic              req_bad;
   logic              accept;
   logic              in_access;
   logic [31:0]       merged_word;
   logic [31:0]       load_data;

   assign req_size_e = dmem_size_e'(req_size);
   assign req_bad    = is_bad_request(req_size_e, req_addr[1:0]);
   assign accept     = req_valid && (state_q == ST_IDLE);
   assign in_access  = (state_q == ST_RD)     || (state_q == ST_WR) ||
                       (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);

   dmem_lane_unit u_lane (
      .mem_word    (mem_rdata),
      .store_data  (wdata_q),
      .size        (size_q),
      .offset      (offset_q),
      .zero_ext    (zero_ext_q),
      .merged_word (merged_word),
      .load_data   (load_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Rejected requests skip memory and respond next cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  state_d = ST_RESP;
               end else if (!req_write) begin
                  state_d = ST_RD;
               end else if (req_size_e == SZ_WORD) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RMW_RD;
               end
            end
         end
         ST_RD:     state_d = ST_RESP;
         ST_WR:     state_d = ST_RESP;
         ST_RMW_RD: state_d = ST_RMW_WR;
         ST_RMW_WR: state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request capture and response registers.
   // Memory read data only arrives in the first RESP cycle, so that cycle
   // forwards the extracted value directly (load_pending_q) and the register
   // captures it for any following stall cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         size_q         <= SZ_BYTE;
         zero_ext_q     <= 1'b0;
         offset_q       <= 2'b00;
         wdata_q        <= '0;
         mem_addr_q     <= '0;
         rsp_rdata_q    <= '0;
         rsp_err_q      <= 1'b0;
         load_pending_q <= 1'b0;
      end else begin
         load_pending_q <= (state_q == ST_RD);

         if (accept) begin
            size_q      <= req_size_e;
            zero_ext_q  <= req_unsigned;
            offset_q    <= req_addr[1:0];
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= req_bad;
            // Rejected requests leave the memory bus untouched.
            if (!req_bad) begin
               mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
            end
         end

         if (in_access && mem_err) begin
            rsp_err_q <= 1'b1;
         end

         if (load_pending_q && !rsp_err_q) begin
            rsp_rdata_q <= load_data;
         end
      end
   end

   // Output decode. The write strobe is killed while reset is high so an
   // access in flight cannot leave a partial write behind.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_WR: begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
         end
         ST_RMW_WR: begin
            mem_we    = 1'b1;
            mem_wdata = merged_word;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
      if (reset) begin
         mem_we = 1'b0;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = (load_pending_q && !rsp_err_q) ? load_data : rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed and randomized stimulus for dmem_access_ctrl against a word-array
// memory and a byte-lane reference model of loads and stores.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_err      (mem_err),
      .busy         (busy)
   );

   // Synchronous-read memory: 256 words, data returned the cycle after the
   // address is presented. Word 0x3FC reports a memory error.
   logic [31:0] ram [0:255] = '{default: 32'h0};
   logic        pre_en   = 1'b0;
   logic [7:0]  pre_idx  = 8'h0;
   logic [31:0] pre_data = 32'h0;
   int          we_count = 0;
   logic [31:0] last_waddr = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   always @(posedge clk) begin
      if (pre_en) begin
         ram[pre_idx] <= pre_data;
      end else if (mem_we) begin
         ram[mem_addr[9:2]] <= mem_wdata;
         we_count   <= we_count + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[9:2]];
   end

   assign mem_err = (mem_addr == 32'h0000_03FC);

   // Reference model: byte-addressed view of the same memory.
   logic [31:0] ref_mem [0:255] = '{default: 32'h0};

   function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] addr);
      logic [31:0] w;
      logic [31:0] v;
      int          sh;
      w = ref_mem[addr[9:2]];
      case (size)
         2'b00: begin
            sh = int'(addr[1:0]) * 8;
            v  = (w >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'b01: begin
            sh = int'(addr[1]) * 16;
            v  = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                       input logic [31:0] data);
      logic [31:0] w;
      logic [31:0] mask;
      int          sh;
      w = ref_mem[addr[9:2]];
      case (size)
         2'b00: begin
            sh   = int'(addr[1:0]) * 8;
            mask = 32'h0000_00FF << sh;
            w    = (w & ~mask) | ((data & 32'h0000_00FF) << sh);
         end
         2'b01: begin
            sh   = int'(addr[1]) * 16;
            mask = 32'h0000_FFFF << sh;
            w    = (w & ~mask) | ((data & 32'h0000_FFFF) << sh);
         end
         default: w = data;
      endcase
      ref_mem[addr[9:2]] = w;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      checkOutput({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
      checkOutput({tag, "_mem_we"},    32'(mem_we), 32'd0);
      checkOutput({tag, "_mem_addr"},  mem_addr, 32'd0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_busy"},      32'(busy), 32'd0);
   endtask

   task automatic preloadWord(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = addr[9:2];
      pre_data = data;
      @(negedge clk);
      pre_en = 1'b0;
      ref_mem[addr[9:2]] = data;
   endtask

   // One request/response transaction. hold = cycles rsp_ready stays low
   // after the response appears.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] data,
                                input int hold, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat, input int exp_we);
      int we_start;
      int lat;
      @(negedge clk);
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = data;
      rsp_ready    = (hold == 0);
      we_start     = we_count;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_latency", lat, exp_lat);
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("stall_rsp_rdata", rsp_rdata, exp_rdata);
         checkOutput("stall_rsp_err", 32'(rsp_err), 32'(exp_err));
         checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("post_req_ready", 32'(req_ready), 32'd1);
      checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("write_count", we_count - we_start, exp_we);
   endtask

   // Transaction with expectations taken from the reference model.
   task automatic runTxn(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input int hold);
      logic        bad;
      logic [31:0] er;
      int          el;
      int          ew;
      bad = model_bad(sz, addr);
      if (bad) begin
         er = 32'h0; el = 1; ew = 0;
      end else if (!wr) begin
         er = model_load(sz, uns, addr); el = 2; ew = 0;
      end else begin
         er = 32'h0; el = (sz == 2'b10) ? 2 : 3; ew = 1;
      end
      applyStimulus(wr, sz, uns, addr, data, hold, er, bad, el, ew);
      if (wr && !bad) model_store(sz, addr, data);
   endtask

   initial begin
      int we_start;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      rsp_ready    = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;

      $display("[TB] word store then load");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2, 1);
      checkOutput("sw_waddr", last_waddr, 32'h100);
      checkOutput("sw_wdata", last_wdata, 32'hDEADBEEF);
      model_store(2'b10, 32'h100, 32'hDEADBEEF);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 2, 0);

      $display("[TB] byte store read-modify-write");
      preloadWord(32'h200, 32'h11223344);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AA, 0, 32'h0, 1'b0, 3, 1);
      checkOutput("sb_waddr", last_waddr, 32'h200);
      checkOutput("sb_wdata", last_wdata, 32'h1122AA44);
      model_store(2'b00, 32'h201, 32'h000000AA);

      $display("[TB] sign and zero extension");
      preloadWord(32'h300, 32'h80FF7F01);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 0, 32'hFFFFFFFF, 1'b0, 2, 0);
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 0, 32'h000000FF, 1'b0, 2, 0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 0, 32'hFFFF80FF, 1'b0, 2, 0);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 0, 32'h00007F01, 1'b0, 2, 0);

      $display("[TB] misaligned and illegal requests");
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 0, 32'h0, 1'b1, 1, 0);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h100, 32'h5555, 0, 32'h0, 1'b1, 1, 0);

      $display("[TB] response backpressure");
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5, 32'hDEADBEEF, 1'b0, 2, 0);

      $display("[TB] memory error");
      preloadWord(32'h3FC, 32'h12345678);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 0, 32'h0, 1'b1, 2, 0);

      $display("[TB] reset during read-modify-write");
      preloadWord(32'h240, 32'hCAFEF00D);
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h241;
      req_wdata    = 32'h55;
      we_start     = we_count;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("rmw_rd_busy", 32'(busy), 32'd1);
      checkOutput("rmw_rd_we", 32'(mem_we), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkResetValues("midreset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midreset_writes", we_count - we_start, 32'd0);
      checkOutput("midreset_mem", ram[8'h90], 32'hCAFEF00D);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 150; n++) begin
         logic        wr;
         logic [1:0]  sz;
         logic        uns;
         logic [31:0] addr;
         logic [31:0] data;
         int          hold;
         wr   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         uns  = 1'($urandom_range(0, 1));
         addr = $urandom_range(0, 32'h3FB);
         data = $urandom;
         hold = int'($urandom_range(0, 2));
         runTxn(wr, sz, uns, addr, data, hold);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
